// File: rtl/sr_flag_bank.sv
// Bank of WIDTH sticky set/reset flags with parallel load, optional edge-qualified set,
// per-bit rise pulses and a masked interrupt. Optional overrun flags: SR_FLAG_BANK_OVR_EN.
module sr_flag_bank #(
   parameter int               WIDTH         = 8,
   parameter int               CONFLICT_MODE = 1,
   parameter int               EDGE_SET      = 0,
   parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [WIDTH-1:0] irq_mask,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] rise,
   output logic             irq
`ifdef SR_FLAG_BANK_OVR_EN
   ,
   output logic [WIDTH-1:0] ovr
`endif
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] s_eff;
   logic [WIDTH-1:0] rise_reg;
   logic             irq_reg;

   // The set history only exists when set is edge-qualified.
   generate
      if (EDGE_SET != 0) begin : g_edge
         logic [WIDTH-1:0] set_d_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) set_d_reg <= '0;
            else     set_d_reg <= set;
         end
         assign s_eff = set & ~set_d_reg;
      end else begin : g_level
         assign s_eff = set;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic bit_next;
         always_comb begin
            bit_next = q_reg[gi];
            if (load) begin
               bit_next = load_data[gi];
            end else if (s_eff[gi] && clr[gi]) begin
               case (CONFLICT_MODE)
                  1:       bit_next = 1'b1;
                  2:       bit_next = 1'b0;
                  3:       bit_next = ~q_reg[gi];
                  default: bit_next = q_reg[gi];
               endcase
            end else if (s_eff[gi]) begin
               bit_next = 1'b1;
            end else if (clr[gi]) begin
               bit_next = 1'b0;
            end
         end
         assign q_next[gi] = bit_next;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg    <= RESET_VAL;
         rise_reg <= '0;
         irq_reg  <= 1'b0;
      end else begin
         q_reg    <= q_next;
         rise_reg <= ~q_reg & q_next;
         irq_reg  <= |(q_next & irq_mask);
      end
   end

   assign q    = q_reg;
   assign qn   = ~q_reg;
   assign rise = rise_reg;
   assign irq  = irq_reg;

`ifdef SR_FLAG_BANK_OVR_EN
   logic [WIDTH-1:0] ovr_reg;
   logic [WIDTH-1:0] ovr_next;

   // A set landing on an already-set flag marks overrun; a plain clear or a load wipes it.
   always_comb begin
      ovr_next = '0;
      if (!load)
         ovr_next = (s_eff & q_reg) | (ovr_reg & ~(clr & ~s_eff));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovr_reg <= '0;
      else     ovr_reg <= ovr_next;
   end

   assign ovr = ovr_reg;
`endif

endmodule

// File: tb/tb_sr_flag_bank.sv
// Bench for sr_flag_bank: six instances (all conflict modes, an out-of-range mode, edge set)
// driven in parallel and compared against a rule-level reference model.
module tb_sr_flag_bank;

   localparam int N = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] set, clr, load_data, irq_mask;
   logic       load;

   logic [7:0] q_o    [N];
   logic [7:0] qn_o   [N];
   logic [7:0] rise_o [N];
   logic       irq_o  [N];
`ifdef SR_FLAG_BANK_OVR_EN
   logic [7:0] ovr_o  [N];
`endif

   always #5 clk = ~clk;

   function automatic int mode_of(int i);
      return (i == 5) ? 7 : (i == 4) ? 1 : i;
   endfunction
   function automatic logic [7:0] rv_of(int i);
      return (i == 4) ? 8'h00 : 8'hA5;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         sr_flag_bank #(
            .WIDTH(8), .CONFLICT_MODE(mode_of(gi)), .EDGE_SET((gi == 4) ? 1 : 0),
            .RESET_VAL(rv_of(gi))
         ) u_dut (
            .clk(clk), .rst(rst), .set(set), .clr(clr), .load(load),
            .load_data(load_data), .irq_mask(irq_mask),
            .q(q_o[gi]), .qn(qn_o[gi]), .rise(rise_o[gi]), .irq(irq_o[gi])
`ifdef SR_FLAG_BANK_OVR_EN
            , .ovr(ovr_o[gi])
`endif
         );
      end
   endgenerate

   // Reference model state
   logic [7:0] mq [N], mrise [N], msd [N], movr [N];
   logic       mirq [N];
   int checks = 0;
   int errors = 0;
   int txn    = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (txn %0d)", tag, obs, exp, txn);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mq[i] = rv_of(i); mrise[i] = '0; msd[i] = '0; movr[i] = '0; mirq[i] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("q%0d", i),    q_o[i],    mq[i]);
         chk($sformatf("qn%0d", i),   qn_o[i],   ~mq[i]);
         chk($sformatf("rise%0d", i), rise_o[i], mrise[i]);
         chk($sformatf("irq%0d", i),  {7'b0, irq_o[i]}, {7'b0, mirq[i]});
`ifdef SR_FLAG_BANK_OVR_EN
         chk($sformatf("ovr%0d", i),  ovr_o[i],  movr[i]);
`endif
      end
   endtask

   // One clock: model applies the flag rules to the current inputs, then both are compared.
   task automatic step();
      logic [7:0] nq [N], no [N];
      for (int i = 0; i < N; i++) begin
         for (int b = 0; b < 8; b++) begin
            logic se, cur;
            cur = mq[i][b];
            se  = (i == 4) ? (set[b] && !msd[i][b]) : set[b];
            if (load)                nq[i][b] = load_data[b];
            else if (se && clr[b]) begin
               case (mode_of(i))
                  1: nq[i][b] = 1'b1;
                  2: nq[i][b] = 1'b0;
                  3: nq[i][b] = !cur;
                  default: nq[i][b] = cur;
               endcase
            end
            else if (se)             nq[i][b] = 1'b1;
            else if (clr[b])         nq[i][b] = 1'b0;
            else                     nq[i][b] = cur;
            if (load)                no[i][b] = 1'b0;
            else if (se && cur)      no[i][b] = 1'b1;
            else if (clr[b] && !se)  no[i][b] = 1'b0;
            else                     no[i][b] = movr[i][b];
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         mrise[i] = nq[i] & ~mq[i];
         mirq[i]  = (nq[i] & irq_mask) != 8'h00;
         mq[i]    = nq[i];
         movr[i]  = no[i];
         msd[i]   = set;
      end
      txn++;
      check_all();
      $display("txn %0d set=%h clr=%h load=%b ld=%h mask=%h q0=%h q3=%h q4=%h",
               txn, set, clr, load, load_data, irq_mask, q_o[0], q_o[3], q_o[4]);
   endtask

   task automatic drive(input logic [7:0] s, input logic [7:0] c, input logic l,
                        input logic [7:0] ld);
      set = s; clr = c; load = l; load_data = ld;
   endtask

   initial begin
      rst = 1'b1;
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      irq_mask = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Load 3C, then assert reset between edges and check it acts immediately
      drive(8'h00, 8'h00, 1'b1, 8'h3C); step();
      drive(8'h00, 8'h00, 1'b0, 8'h00); step();
      #1 rst = 1'b1;
      #1 model_reset();
      check_all();
      chk("async_q0", q_o[0], 8'hA5);
      chk("async_qn0", qn_o[0], 8'h5A);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("no_rise_after_release", rise_o[0], 8'h00);

      // Single set then clear
      drive(8'h00, 8'h00, 1'b1, 8'h00); step();
      drive(8'h01, 8'h00, 1'b0, 8'h00); step();
      chk("set_q", q_o[0], 8'h01);
      chk("set_rise", rise_o[0], 8'h01);
      drive(8'h00, 8'h01, 1'b0, 8'h00); step();
      chk("clr_q", q_o[0], 8'h00);
      chk("clr_rise", rise_o[0], 8'h00);
      drive(8'h00, 8'h00, 1'b0, 8'h00); step();

      // Conflict resolution from 0F
      drive(8'h00, 8'h00, 1'b1, 8'h0F); step();
      drive(8'hFF, 8'hFF, 1'b0, 8'h00); step();
      chk("conf_m0", q_o[0], 8'h0F);
      chk("conf_m1", q_o[1], 8'hFF);
      chk("conf_m1_rise", rise_o[1], 8'hF0);
      chk("conf_m2", q_o[2], 8'h00);
      chk("conf_m3", q_o[3], 8'hF0);
      chk("conf_m3_rise", rise_o[3], 8'hF0);
      chk("conf_m7_hold", q_o[5], 8'h0F);

      // Held set+clr keeps toggling in mode 3
      drive(8'h00, 8'h00, 1'b1, 8'h00); step();
      drive(8'hFF, 8'hFF, 1'b0, 8'h00); repeat (3) step();

      // Edge-qualified set on bit 2 with a clear in the second cycle
      drive(8'h00, 8'h00, 1'b1, 8'h00); step();
      drive(8'h04, 8'h00, 1'b0, 8'h00); step();
      chk("edge_first", q_o[4], 8'h04);
      drive(8'h04, 8'h04, 1'b0, 8'h00); step();
      drive(8'h04, 8'h00, 1'b0, 8'h00); repeat (2) step();
      chk("edge_held", q_o[4], 8'h00);
      drive(8'h00, 8'h00, 1'b0, 8'h00); step();
      drive(8'h04, 8'h00, 1'b0, 8'h00); step();
      chk("edge_rearm", q_o[4], 8'h04);

      // Load overrides set; irq follows mask one cycle late
      irq_mask = 8'h80;
      drive(8'h7E, 8'h00, 1'b1, 8'h81); step();
      chk("load_q", q_o[1], 8'h81);
      chk("load_irq", {7'b0, irq_o[1]}, 8'h01);
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      irq_mask = 8'h00; step();
      chk("mask_off_irq", {7'b0, irq_o[1]}, 8'h00);

      // Overrun on bit 3
      drive(8'h00, 8'h00, 1'b1, 8'h08); step();
      drive(8'h08, 8'h00, 1'b0, 8'h00); step();
      drive(8'h00, 8'h08, 1'b0, 8'h00); step();
      chk("ovr_clr_q", q_o[1], 8'h00);

      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         drive($urandom & $urandom, $urandom & $urandom, ($urandom_range(15) == 0),
               8'($urandom));
         irq_mask = 8'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_flag_bank.md
Name: sr_flag_bank

Overview:
- Parametrised, clocked bank of WIDTH set/reset flag bits.
- Each bit is a registered SR element with a defined response to simultaneous set and clear, so no bit ever enters an indeterminate state.
- Adds parallel load, optional edge-qualified set, a rising-transition pulse per bit and a masked, OR-reduced interrupt output.
- Used as a sticky status/event register between datapath blocks and control logic.

Parameters:
- WIDTH, 8: number of flag bits (>=1).
- CONFLICT_MODE, 1: response when effective set and clr are both 1 on a bit. 0 = hold, 1 = set wins, 2 = clear wins, 3 = toggle. Any other value behaves as 0.
- EDGE_SET, 0: 0 = set is level-sensitive; 1 = set acts only on a 0->1 transition of the set input bit.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- set  input  WIDTH  per-bit set request
- clr  input  WIDTH  per-bit clear request
- load  input  1  parallel load strobe; overrides set/clr on all bits
- load_data  input  WIDTH  value written when load=1
- irq_mask  input  WIDTH  per-bit interrupt enable, 1 = enabled
- q  output  WIDTH  flag state (registered)
- qn  output  WIDTH  ~q, always the exact complement of q (combinational from the q register)
- rise  output  WIDTH  one-cycle pulse per bit on a q 0->1 transition
- irq  output  1  registered OR of (q & irq_mask)

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - q = RESET_VAL, qn = ~RESET_VAL.
  - rise = 0, irq = 0, set_d (edge-detect history) = 0.
  - Reset asserted mid-operation forces these values immediately, regardless of clk.
- Effective set per bit i:
  - s_eff[i] = set[i] when EDGE_SET=0.
  - s_eff[i] = set[i] & ~set_d[i] when EDGE_SET=1; set_d <= set every cycle.
  - Because set_d resets to 0, a set bit held high across reset release counts as an edge on the first clock after release.
- Next state per bit, evaluated in priority order:
  - load=1: q_next = load_data[i].
  - s_eff & clr: resolved by CONFLICT_MODE (hold q, 1, 0, or ~q).
  - s_eff only: q_next = 1.
  - clr only: q_next = 0.
  - neither: q_next = q.
- q <= q_next on every rising edge of clk. Latency from request to q is one cycle.
- rise <= ~q & q_next, so rise[i] is high in the same cycle q[i] first reads 1.
  - rise is also generated by a load that takes a bit 0->1, and by a toggle that takes a bit 0->1.
  - No rise on reset release, even if RESET_VAL has ones.
- irq <= |(q_next & irq_mask), so irq is aligned with q.
  - A mask change takes effect one cycle later.
  - No clr: irq stays high until the flags or the mask are cleared.
- Set on a bit already at 1 has no effect on q and produces no rise.
- In CONFLICT_MODE=3, holding both set and clr high (EDGE_SET=0) toggles the bit every cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro SR_FLAG_BANK_OVR_EN.
- When defined, adds output port ovr (output, WIDTH): sticky overrun flag per bit.
  - ovr[i] sets when s_eff[i]=1, q[i]=1 and load=0, i.e. a set arrives on an already-set flag.
  - ovr[i] clears on clr[i]=1 without s_eff[i], or when load=1.
  - Reset value 0; ovr updates on the same edge as q.
- When undefined, the ovr port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset value (WIDTH=8, RESET_VAL=8'hA5, rst pulsed mid-run while q=8'h3C): q=8'hA5 and qn=8'h5A immediately, with no clk edge; rise=0, irq=0; no rise on the first cycle after release.
- Set/clear and rise (set=8'h01 for one cycle, then clr=8'h01): q=8'h01 one cycle after the set with rise=8'h01 for exactly that cycle; q=8'h00 one cycle after the clr; rise=0 throughout the clear.
- Conflict resolution (set=clr=8'hFF from q=8'h0F, one cycle, each mode):
  - mode 0: q=8'h0F.
  - mode 1: q=8'hFF, rise=8'hF0.
  - mode 2: q=8'h00.
  - mode 3: q=8'hF0, rise=8'hF0.
- Edge set (EDGE_SET=1, set[2] held high for 4 cycles from q=0, clr[2] pulsed in cycle 2): q[2] rises once, clears after the clr and stays 0; it sets again only after set[2] drops and re-rises.
- Load and irq (load=1, load_data=8'h81, irq_mask=8'h80, simultaneous set=8'h7E): q=8'h81 (load overrides set), irq=1 in the same cycle; irq_mask->0 gives irq=0 one cycle later.
- Overrun (SR_FLAG_BANK_OVR_EN defined, q[3]=1, set[3]=1): ovr[3]=1 next cycle; clr[3] alone -> ovr[3]=0 and q[3]=0. With the macro undefined, the bench compiles without ovr.
